// File: rtl/vga_pkg.sv
// vga_pkg: default raster timing and helpers shared by
// the scan controller and its fetch scheduler.
package vga_pkg;

    localparam int COORD_W = 16;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int h_total(input int vis, input int fp,
                                   input int sp, input int bp);
        return vis + fp + sp + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp,
                                   input int sp, input int bp);
        return vis + fp + sp + bp;
    endfunction

endpackage

// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched: issues one line-fetch per visible line and
// abandons it with an underrun pulse if its line start arrives first.
module vga_fetch_sched
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_TOTAL   = v_total(DEF_V_VISIBLE, DEF_V_FRONT,
                                      DEF_V_SYNC, DEF_V_BACK),
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_i,
    input  logic [HW-1:0] h_next_i,
    input  logic [VW-1:0] v_next_i,
    input  logic          fetch_ack_i,
    output logic          fetch_req_o,
    output logic [VW-1:0] fetch_line_o,
    output logic          underrun_o
);

    localparam logic [HW-1:0] H_TRIG = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);

    logic [VW-1:0] line_n;
    logic          trig;
    logic          deadline;

    logic          req_q, req_d;
    logic          urun_q, urun_d;
    logic [VW-1:0] line_q, line_d;

    assign line_n   = (v_next_i == V_LAST) ? '0 : v_next_i + VW'(1);
    assign trig     = enable_i && (h_next_i == H_TRIG) && (line_n < V_VIS);
    assign deadline = enable_i && (h_next_i == '0) && (v_next_i == line_q);

    // An ack on the deadline edge still counts as on time.
    always_comb begin
        req_d  = req_q;
        line_d = line_q;
        urun_d = 1'b0;
        if (trig) begin
            req_d  = 1'b1;
            line_d = line_n;
        end else if (req_q && fetch_ack_i) begin
            req_d = 1'b0;
        end else if (req_q && deadline) begin
            req_d  = 1'b0;
            urun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            line_q <= '0;
            urun_q <= 1'b0;
        end else begin
            req_q  <= req_d;
            line_q <= line_d;
            urun_q <= urun_d;
        end
    end

    assign fetch_req_o  = req_q;
    assign fetch_line_o = line_q;
    assign underrun_o   = urun_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster counters, sync/active decode and markers;
// every output is registered from the position being entered.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_VISIBLE        = DEF_H_VISIBLE,
    parameter int H_FRONT          = DEF_H_FRONT,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BACK           = DEF_H_BACK,
    parameter int V_VISIBLE        = DEF_V_VISIBLE,
    parameter int V_FRONT          = DEF_V_FRONT,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BACK           = DEF_V_BACK,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start,
    output logic               line_start,
    output logic               fetch_req,
    output logic [COORD_W-1:0] fetch_line,
    input  logic               fetch_ack,
    output logic               underrun
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic SYNC_ON  = SYNC_ACTIVE_HIGH;
    localparam logic SYNC_OFF = ~SYNC_ACTIVE_HIGH;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          fs_q, fs_d;
    logic          ls_q, ls_d;
    logic [VW-1:0] sched_line;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (enable) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_comb begin
        hs_d  = (h_d >= H_SS && h_d <= H_SE) ? SYNC_ON : SYNC_OFF;
        vs_d  = (v_d >= V_SS && v_d <= V_SE) ? SYNC_ON : SYNC_OFF;
        act_d = (h_d < H_VIS) && (v_d < V_VIS);
        fs_d  = enable && (h_d == '0) && (v_d == '0);
        ls_d  = enable && (h_d == '0) && (v_d < V_VIS);
    end

    // Reset lands in the vertical front porch so line 0 gets prefetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= V_VIS;
            hs_q  <= SYNC_OFF;
            vs_q  <= SYNC_OFF;
            act_q <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
        end
    end

    vga_fetch_sched #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .V_TOTAL   (V_TOTAL),
        .HW        (HW),
        .VW        (VW)
    ) u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .h_next_i     (h_d),
        .v_next_i     (v_d),
        .fetch_ack_i  (fetch_ack),
        .fetch_req_o  (fetch_req),
        .fetch_line_o (sched_line),
        .underrun_o   (underrun)
    );

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign active      = act_q;
    assign pixel_x     = COORD_W'(h_q);
    assign pixel_y     = COORD_W'(v_q);
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign fetch_line  = COORD_W'(sched_line);

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: randomized enable/ack stimulus against a
// linear-position reference model of the raster and fetch rules.
module tb_vga_scan_ctrl;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 480, VF = 10, VS = 2, VB = 33;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int MID_P = 14 * HT + 642;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        hsync, vsync, active;
    logic [15:0] pixel_x, pixel_y, fetch_line;
    logic        frame_start, line_start, fetch_req, underrun;

    vga_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .line_start  (line_start),
        .fetch_req   (fetch_req),
        .fetch_line  (fetch_line),
        .fetch_ack   (fetch_ack),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: linear position within the frame
    int p;
    int m_frames;
    bit m_req;
    int m_line;
    bit m_urun, e_fs, e_ls;

    int  iter, first_fs, n_ls, n_urun, hs_y3, vs_pre, act_y2;
    int  lat, frz;
    bit  req_seen, frz_done, in_frz, hit;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        p      = VV * HT;
        m_req  = 1'b0;
        m_line = 0;
        m_urun = 1'b0;
        e_fs   = 1'b0;
        e_ls   = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit ack);
        int x, y;
        m_urun = 1'b0;
        if (en) p = (p + 1) % FRAME;
        x = p % HT;
        y = p / HT;
        e_fs = en && (p == 0);
        e_ls = en && (x == 0) && (y < VV);
        if (e_fs) m_frames++;
        if (en && x == HV && ((y + 1) % VT) < VV) begin
            m_req  = 1'b1;
            m_line = (y + 1) % VT;
        end else if (m_req && ack) begin
            m_req = 1'b0;
        end else if (m_req && en && x == 0 && y == m_line) begin
            m_req  = 1'b0;
            m_urun = 1'b1;
        end
    endtask

    task automatic cmp_all();
        int x, y;
        bit in_hs, in_vs;
        x = p % HT;
        y = p / HT;
        in_hs = (x >= HV + HF) && (x < HV + HF + HS);
        in_vs = (y >= VV + VF) && (y < VV + VF + VS);
        chk("pixel_x", 32'(pixel_x), x);
        chk("pixel_y", 32'(pixel_y), y);
        chk("hsync", 32'(hsync), 32'(!in_hs));
        chk("vsync", 32'(vsync), 32'(!in_vs));
        chk("active", 32'(active), 32'(x < HV && y < VV));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("fetch_req", 32'(fetch_req), 32'(m_req));
        chk("fetch_line", 32'(fetch_line), m_line);
        chk("underrun", 32'(underrun), 32'(m_urun));
    endtask

    task automatic drive(input int x, input int y);
        bit en_n, ack_n;
        en_n   = 1'b1;
        in_frz = 1'b0;
        if (m_frames == 1 && !frz_done && x == 100 && y == 10) begin
            frz      = 50;
            frz_done = 1'b1;
        end
        if (frz > 0) begin
            en_n   = 1'b0;
            in_frz = 1'b1;
            frz--;
        end else if (m_frames == 1 && y >= 11 && y <= 13) begin
            en_n = ($urandom_range(0, 3) != 0);
        end
        ack_n = 1'b0;
        if (m_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                lat = (m_line == 15) ? 30 : $urandom_range(0, 20);
            end
            if (m_line == 6) begin
                ack_n = 1'b0;
            end else if (m_line == 9) begin
                ack_n = (x == HT - 1) && (y == 8);
            end else begin
                ack_n = (lat == 0);
                if (lat > 0) lat--;
            end
        end else begin
            req_seen = 1'b0;
            ack_n = ($urandom_range(0, 7) == 0);
        end
        enable    = en_n;
        fetch_ack = ack_n;
    endtask

    task automatic cycle();
        int x, y;
        bit was_frz;
        was_frz = in_frz;
        @(negedge clk);
        iter++;
        model_step(enable, fetch_ack);
        cmp_all();
        x = p % HT;
        y = p / HT;
        if (frame_start === 1'b1 && first_fs < 0) first_fs = iter;
        if (line_start === 1'b1) n_ls++;
        if (underrun === 1'b1) n_urun++;
        if (m_frames == 1 && y == 3 && hsync === 1'b0) hs_y3++;
        if (m_frames == 0 && vsync === 1'b0) vs_pre++;
        if (m_frames == 1 && y == 2 && active === 1'b1) act_y2++;
        if (m_frames == 1 && p == 6 * HT)
            chk("urun_at_0_6", 32'(underrun), 1);
        if (m_frames == 1 && p == 6 * HT + HV)
            chk("req_line7", 32'(fetch_line), 7);
        if (m_frames == 1 && p == 9 * HT) begin
            chk("dl_ack_urun", 32'(underrun), 0);
            chk("dl_ack_req", 32'(fetch_req), 0);
        end
        if (was_frz) begin
            chk("hold_x", 32'(pixel_x), 100);
            chk("hold_y", 32'(pixel_y), 10);
            chk("hold_ls", 32'(line_start), 0);
        end
        drive(x, y);
    endtask

    initial begin
        iter = 0; first_fs = -1; n_ls = 0; n_urun = 0;
        hs_y3 = 0; vs_pre = 0; act_y2 = 0;
        lat = 0; frz = 0; req_seen = 0; frz_done = 0; in_frz = 0;
        hit = 0; m_frames = 0;
        model_reset();

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_all();
        rst_n     = 1'b1;
        enable    = 1'b1;
        fetch_ack = 1'b0;

        for (int i = 0; i < 60000 && !hit; i++) begin
            cycle();
            if (m_frames == 1 && p == MID_P) hit = 1'b1;
        end
        chk("reach_mid_point", 32'(hit), 1);
        chk("first_fs_clk", first_fs, 36000);
        chk("line_start_cnt", n_ls, 15);
        chk("underrun_cnt", n_urun, 1);
        chk("hsync_len_y3", hs_y3, 96);
        chk("vsync_low_clks", vs_pre, 2 * HT);
        chk("active_len_y2", act_y2, HV);
        chk("mid_req_pending", 32'(fetch_req), 1);

        rst_n = 1'b0;
        #1;
        chk("mid_rst_x", 32'(pixel_x), 0);
        chk("mid_rst_y", 32'(pixel_y), VV);
        chk("mid_rst_req", 32'(fetch_req), 0);
        chk("mid_rst_urun", 32'(underrun), 0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            cmp_all();
        end
        rst_n     = 1'b1;
        enable    = 1'b1;
        fetch_ack = 1'b0;
        in_frz    = 1'b0;
        repeat (1000) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
